// File: rtl/serial_add_arb.sv
// serial_add_arb: round-robin arbiter in front of a single bit-serial
// full-adder stage. The winner's operands are shifted through the 1-bit
// stage LSB-first over N cycles; the result, carry-out and owner ID are
// presented with a one-cycle done pulse and then held until the next grant.
module serial_add_arb #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic         req1,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic         done,
    output logic         owner,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Carry of a 1-bit full adder.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Sum bit of a 1-bit full adder.
    function automatic logic xor3(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    state_t          state_r, state_s;
    logic [N-1:0]    a_sh_r, a_sh_s;
    logic [N-1:0]    b_sh_r, b_sh_s;
    logic            carry_r, carry_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            last_r, last_s;
    logic            gnt0_r, gnt0_s;
    logic            gnt1_r, gnt1_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            owner_r, owner_s;
    logic [N-1:0]    sum_r, sum_s;
    logic            cout_r, cout_s;
    logic            pick0_s;
    logic            pick1_s;
    logic            bit_s;

    // Next-state and next-output logic for the arbiter/serial-adder FSM.
    always_comb begin
        state_s = state_r;
        a_sh_s  = a_sh_r;
        b_sh_s  = b_sh_r;
        carry_s = carry_r;
        cnt_s   = cnt_r;
        last_s  = last_r;
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        busy_s  = busy_r;
        done_s  = 1'b0;
        owner_s = owner_r;
        sum_s   = sum_r;
        cout_s  = cout_r;
        // On a tie the requester that was not served last wins.
        pick0_s = req0 && (!req1 || (last_r == 1'b1));
        pick1_s = req1 && (!req0 || (last_r == 1'b0));
        bit_s   = xor3(a_sh_r[0], b_sh_r[0], carry_r);

        case (state_r)
            ST_IDLE: begin
                if (pick0_s) begin
                    a_sh_s  = a0;
                    b_sh_s  = b0;
                    carry_s = 1'b0;
                    cnt_s   = {CW{1'b0}};
                    owner_s = 1'b0;
                    last_s  = 1'b0;
                    gnt0_s  = 1'b1;
                    busy_s  = 1'b1;
                    cout_s  = 1'b0;
                    state_s = ST_RUN;
                end else if (pick1_s) begin
                    a_sh_s  = a1;
                    b_sh_s  = b1;
                    carry_s = 1'b0;
                    cnt_s   = {CW{1'b0}};
                    owner_s = 1'b1;
                    last_s  = 1'b1;
                    gnt1_s  = 1'b1;
                    busy_s  = 1'b1;
                    cout_s  = 1'b0;
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                carry_s = maj3(a_sh_r[0], b_sh_r[0], carry_r);
                a_sh_s  = {1'b0, a_sh_r[N-1:1]};
                b_sh_s  = {1'b0, b_sh_r[N-1:1]};
                sum_s   = {bit_s, sum_r[N-1:1]};
                cnt_s   = cnt_r + CW'(1);
                if (cnt_r == CNT_LAST) begin
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    cout_s  = maj3(a_sh_r[0], b_sh_r[0], carry_r);
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_sh_r  <= {N{1'b0}};
            b_sh_r  <= {N{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            last_r  <= 1'b1;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            owner_r <= 1'b0;
            sum_r   <= {N{1'b0}};
            cout_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            a_sh_r  <= a_sh_s;
            b_sh_r  <= b_sh_s;
            carry_r <= carry_s;
            cnt_r   <= cnt_s;
            last_r  <= last_s;
            gnt0_r  <= gnt0_s;
            gnt1_r  <= gnt1_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            owner_r <= owner_s;
            sum_r   <= sum_s;
            cout_r  <= cout_s;
        end
    end

    assign gnt0  = gnt0_r;
    assign gnt1  = gnt1_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign owner = owner_r;
    assign sum   = sum_r;
    assign cout  = cout_r;

endmodule

// File: tb/tb_serial_add_arb.sv
// Self-checking bench for serial_add_arb: table of single-requester vectors,
// hand sequences for arbitration/abort corners, and a randomized run against
// an arithmetic round-robin reference model.
module tb_serial_add_arb;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         req0;
    logic [N-1:0] a0;
    logic [N-1:0] b0;
    logic         req1;
    logic [N-1:0] a1;
    logic [N-1:0] b1;
    logic         gnt0;
    logic         gnt1;
    logic         busy;
    logic         done;
    logic         owner;
    logic [N-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    serial_add_arb #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .a0    (a0),
        .b0    (b0),
        .req1  (req1),
        .a1    (a1),
        .b1    (b1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .done  (done),
        .owner (owner),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         r0;
        logic [N-1:0] va0;
        logic [N-1:0] vb0;
        logic         r1;
        logic [N-1:0] va1;
        logic [N-1:0] vb1;
        int           exp_owner;
        logic [N-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({gnt0, gnt1, busy, done, owner, cout, sum});
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 32'd0);
        rst = 1'b0;
    endtask

    // Wait for a grant; returns requester id and cycles waited (-1 on timeout).
    task automatic wait_gnt(output int who, output int lat);
        who = -1;
        lat = 0;
        for (int i = 1; i <= N + 4; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                check("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
                who = gnt0 ? 0 : 1;
                lat = i;
                break;
            end
        end
        if (who < 0) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: no grant within %0d cycles", N + 4);
        end
    endtask

    // Called at the gnt cycle: checks busy window, done pulse, results and hold.
    task automatic finish_txn(input int exp_owner, input logic [N-1:0] exp_sum, input logic exp_cout);
        check("busy_at_gnt", 32'({busy, done}), 32'b10);
        for (int i = 1; i < N; i++) begin
            @(negedge clk);
            check("run_window", 32'({busy, done, gnt0, gnt1}), 32'b1000);
        end
        @(negedge clk);
        check("done_pulse", 32'({busy, done, gnt0, gnt1}), 32'b0100);
        check("sum", 32'(sum), 32'(exp_sum));
        check("cout", 32'(cout), 32'(exp_cout));
        check("owner", 32'(owner), 32'(exp_owner));
        @(negedge clk);
        check("after_done", 32'({busy, done, gnt0, gnt1}), 32'b0000);
        check("sum_hold", 32'(sum), 32'(exp_sum));
        check("cout_hold", 32'(cout), 32'(exp_cout));
        check("owner_hold", 32'(owner), 32'(exp_owner));
    endtask

    vec_t         tbl[6];
    int           who;
    int           lat;
    logic         pend[2];
    logic [N-1:0] ra[2];
    logic [N-1:0] rb[2];
    int           last_served;
    int           exp_w;
    logic [N:0]   full;

    initial begin
        tbl[0] = '{1'b1, 8'h3C, 8'h0F, 1'b0, 8'h00, 8'h00, 0, 8'h4B, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h01, 1, 8'h00, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'hFF, 1, 8'hFE, 1'b1};
        tbl[3] = '{1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 8'h00, 0, 8'h00, 1'b1};
        tbl[4] = '{1'b1, 8'h7F, 8'h01, 1'b0, 8'h00, 8'h00, 0, 8'h80, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1, 8'h00, 1'b0};

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        @(negedge clk);
        do_reset();

        // Quiet period: nothing may move without requests.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_quiet", all_outs(), 32'd0);
        end

        // Table-driven single-requester additions.
        for (int k = 0; k < 6; k++) begin
            req0 = tbl[k].r0; a0 = tbl[k].va0; b0 = tbl[k].vb0;
            req1 = tbl[k].r1; a1 = tbl[k].va1; b1 = tbl[k].vb1;
            wait_gnt(who, lat);
            req0 = 1'b0;
            req1 = 1'b0;
            if (who >= 0) begin
                check("tbl_winner", 32'(who), 32'(tbl[k].exp_owner));
                check("tbl_gnt_latency", 32'(lat), 32'd1);
                finish_txn(tbl[k].exp_owner, tbl[k].exp_sum, tbl[k].exp_cout);
            end
        end

        // Contention after reset: 0, then 1, then 0 again.
        do_reset();
        req0 = 1'b1; a0 = 8'h10; b0 = 8'h20;
        req1 = 1'b1; a1 = 8'h05; b1 = 8'h06;
        wait_gnt(who, lat);
        check("tie_first", 32'(who), 32'd0);
        req0 = 1'b0;
        finish_txn(0, 8'h30, 1'b0);
        wait_gnt(who, lat);
        check("tie_second", 32'(who), 32'd1);
        check("tie_second_latency", 32'(lat), 32'd1);
        req1 = 1'b0;
        finish_txn(1, 8'h0B, 1'b0);
        req0 = 1'b1; req1 = 1'b1;
        wait_gnt(who, lat);
        check("tie_third", 32'(who), 32'd0);
        req0 = 1'b0;
        finish_txn(0, 8'h30, 1'b0);
        wait_gnt(who, lat);
        check("tie_fourth", 32'(who), 32'd1);
        req1 = 1'b0;
        finish_txn(1, 8'h0B, 1'b0);

        // Request raised during another requester's run is not granted early.
        req0 = 1'b1; a0 = 8'h12; b0 = 8'h34;
        wait_gnt(who, lat);
        check("midrun_first", 32'(who), 32'd0);
        req0 = 1'b0;
        req1 = 1'b1; a1 = 8'hAA; b1 = 8'h55;
        finish_txn(0, 8'h46, 1'b0);
        wait_gnt(who, lat);
        check("midrun_second", 32'(who), 32'd1);
        req1 = 1'b0;
        finish_txn(1, 8'hFF, 1'b0);

        // Reset in the middle of a run aborts it without a done pulse.
        req0 = 1'b1; a0 = 8'h55; b0 = 8'h0F;
        wait_gnt(who, lat);
        check("abort_winner", 32'(who), 32'd0);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", all_outs(), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            check("abort_no_done", all_outs(), 32'd0);
        end
        // last_served must be back to 1, so a tie goes to requester 0.
        req0 = 1'b1; a0 = 8'h01; b0 = 8'h01;
        req1 = 1'b1; a1 = 8'h03; b1 = 8'h04;
        wait_gnt(who, lat);
        check("abort_tie", 32'(who), 32'd0);
        req0 = 1'b0;
        finish_txn(0, 8'h02, 1'b0);
        wait_gnt(who, lat);
        check("abort_next", 32'(who), 32'd1);
        req1 = 1'b0;
        finish_txn(1, 8'h07, 1'b0);

        // Randomized traffic against a round-robin arithmetic model.
        do_reset();
        last_served = 1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int t = 0; t < 60; t++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(1, 0) == 1)) begin
                    pend[r] = 1'b1;
                    ra[r] = N'($urandom);
                    rb[r] = N'($urandom);
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[t % 2] = 1'b1;
                ra[t % 2] = N'($urandom);
                rb[t % 2] = N'($urandom);
            end
            req0 = pend[0]; a0 = ra[0]; b0 = rb[0];
            req1 = pend[1]; a1 = ra[1]; b1 = rb[1];
            if (pend[0] && pend[1]) exp_w = (last_served == 1) ? 0 : 1;
            else                    exp_w = pend[0] ? 0 : 1;
            wait_gnt(who, lat);
            if (who < 0) break;
            check("rnd_winner", 32'(who), 32'(exp_w));
            check("rnd_gnt_latency", 32'(lat), 32'd1);
            last_served = exp_w;
            pend[exp_w] = 1'b0;
            if (exp_w == 0) req0 = 1'b0;
            else            req1 = 1'b0;
            full = {1'b0, ra[exp_w]} + {1'b0, rb[exp_w]};
            finish_txn(exp_w, full[N-1:0], full[N]);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
